instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS instruction words.
- Each word is emitted with a sequential word address for writing into instruction memory, e.g. by a program loader or self-test generator.
- A single registered pipeline stage provides backpressure.
- Optional field-legality checking flags malformed requests.

Parameters:
- ADDR_W, 32, width of output word address and base address.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; loads address counter from baseAddr
- baseAddr  input  ADDR_W  start address, must be word aligned
- inValid  input  1  request valid
- inReady  output  1  request accepted when inValid & inReady
- fmt  input  2  0 Register, 1 Immediate, 2 Jump, 3 Coprocessor0
- opCode  input  6  primary opcode
- funct  input  6  SPECIAL/SPECIAL2/COP0 function field
- rs, rt, rd  input  5 each  register fields
- shamt  input  5  shift amount
- immediate  input  26  imm16 in [15:0] (sign-extended form allowed), or jump target
- outValid  output  1  encoded word valid
- outReady  input  1  consumer accepts when outValid & outReady
- outInstr  output  32  encoded instruction
- outAddr  output  ADDR_W  address of outInstr
- outErr  output  1  outInstr came from an illegal request
- errCount  output  ERR_CNT_W  saturating count of emitted error words
- wordCount  output  ADDR_W  words emitted since last start/reset

Behaviour:
- Reset (async, reset_n=0):
  - outValid=0, outInstr=0, outAddr=0, outErr=0, errCount=0, wordCount=0.
  - Address counter=0; pending word discarded.
  - inReady=0 while reset_n=0; inReady=1 from the first edge after release.
- Pipeline and handshake:
  - inReady = ~outValid | outReady (combinational).
  - On accept, the encoded word is registered; outValid=1 the next cycle, giving 1-cycle latency.
  - Back-to-back accepts give one word per cycle.
  - outInstr/outAddr/outErr hold stable while outValid & ~outReady.
  - On output handshake with no new accept, outValid falls next cycle.
- Encoding:
  - fmt 0: {opCode, rs, rt, rd, shamt, funct}.
  - fmt 1: {opCode, rs, rt, immediate[15:0]}.
  - fmt 2: {opCode, immediate[25:0]}.
  - fmt 3: {6'b010000, rs, rt, rd, 5'b0, funct}. When rs[4]=1 (CO bit, e.g. ERET), rt and rd are forced to 0.
- Address counter:
  - Assigned to the word at accept time; advances by 4 per accept.
  - Wraps modulo 2^ADDR_W with no flag.
  - wordCount increments per output handshake and wraps.
- start:
  - Address counter <= baseAddr and wordCount <= 0.
  - A request accepted in the same cycle uses baseAddr; the counter then holds baseAddr+4.
  - A word already pending keeps its old address.
- errCount saturates at all-ones and is cleared only by reset.
- Illegal fmt handling exists only with the checker enabled (see Optional Feature).

Optional Feature:
- Macro INSTR_ENCODER_CHECK_EN.
- Defined: outErr=1 when any of the following holds, with outInstr forced to 32'h0 (NOP) and errCount incremented on output handshake:
  - fmt 0 with opCode not 000000/011100.
  - fmt 1 with immediate[25:16] neither all-0 nor all-1, or opCode in {000000, 000010, 000011, 010000, 011100}.
  - fmt 2 with opCode not 000010/000011.
  - fmt 3 with opCode≠010000.
- Not defined: no checks; outErr and errCount tied to 0; fields packed as given.

Test Plan:
- Reset, start baseAddr=0x00400000, fmt0 opCode=0 rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> next cycle outInstr=0x00221820 (ADD), outAddr=0x00400000.
- fmt1 opCode=0x08 rs=0 rt=8 immediate=0x3FFFFFF (-1), then fmt2 opCode=0x03 immediate=0x0100000, back-to-back with outReady=1 -> 0x2008FFFF @+0, 0x0C100000 @+4, one word per cycle.
- Hold outReady=0 two cycles with inValid=1 -> inReady=0, outInstr stable; release -> next word accepted, no loss or duplication.
- fmt3 rs=0x10 rt=5 rd=7 funct=0x18 -> 0x42000018 (ERET, rt/rd dropped); rs=0 rt=5 rd=12 -> 0x40056000 (MFC0).
- CHECK_EN: fmt1 immediate=0x0012345 -> outErr=1, outInstr=0, errCount=1. Without the macro -> 0x...2345 packed, outErr=0.
- baseAddr=0xFFFFFFF8, three words -> addresses FFFFFFF8, FFFFFFFC, 00000000. reset_n low mid-stall -> outValid=0 immediately; pending word dropped.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder.
// master drives requests and consumes words; slave is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              inValid;
    logic              inReady;
    logic [1:0]        fmt;
    logic [5:0]        opCode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [25:0]       immediate;
    logic              outValid;
    logic              outReady;
    logic [31:0]       outInstr;
    logic [ADDR_W-1:0] outAddr;
    logic              outErr;

    modport master (
        output inValid, fmt, opCode, funct,
        output rs, rt, rd, shamt, immediate,
        output outReady,
        input  inReady, outValid, outInstr,
        input  outAddr, outErr
    );

    modport slave (
        input  inValid, fmt, opCode, funct,
        input  rs, rt, rd, shamt, immediate,
        input  outReady,
        output inReady, outValid, outInstr,
        output outAddr, outErr
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded MIPS fields into 32-bit words with sequential addresses.
// Define INSTR_ENCODER_CHECK_EN to flag illegal requests as NOP + outErr.
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    baseAddr,
    instr_encoder_if.slave       bus,
    output logic [ERR_CNT_W-1:0] errCount,
    output logic [ADDR_W-1:0]    wordCount
);
    logic              live;
    logic              accept;
    logic              out_fire;
    logic [31:0]       packed_word;
    logic [31:0]       word;
    logic              err;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_use;

    // Holds inReady low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign bus.inReady = live & (~bus.outValid | bus.outReady);
    assign accept      = bus.inValid & bus.inReady;
    assign out_fire    = bus.outValid & bus.outReady;

    always_comb begin
        packed_word = '0;
        unique case (bus.fmt)
            2'd0: packed_word = {bus.opCode, bus.rs, bus.rt,
                                 bus.rd, bus.shamt, bus.funct};
            2'd1: packed_word = {bus.opCode, bus.rs, bus.rt,
                                 bus.immediate[15:0]};
            2'd2: packed_word = {bus.opCode, bus.immediate};
            2'd3: begin
                // CO bit set: rt/rd carry no meaning and are zeroed
                if (bus.rs[4])
                    packed_word = {6'b010000, bus.rs, 10'b0,
                                   5'b0, bus.funct};
                else
                    packed_word = {6'b010000, bus.rs, bus.rt,
                                   bus.rd, 5'b0, bus.funct};
            end
        endcase
    end

`ifdef INSTR_ENCODER_CHECK_EN
    logic bad;
    logic imm_ok;

    assign imm_ok = (bus.immediate[25:16] == 10'h000) ||
                    (bus.immediate[25:16] == 10'h3FF);

    always_comb begin
        bad = 1'b0;
        unique case (bus.fmt)
            2'd0: bad = !(bus.opCode == 6'h00 ||
                          bus.opCode == 6'h1C);
            2'd1: bad = !imm_ok ||
                        bus.opCode == 6'h00 ||
                        bus.opCode == 6'h02 ||
                        bus.opCode == 6'h03 ||
                        bus.opCode == 6'h10 ||
                        bus.opCode == 6'h1C;
            2'd2: bad = !(bus.opCode == 6'h02 ||
                          bus.opCode == 6'h03);
            2'd3: bad = bus.opCode != 6'h10;
        endcase
    end

    assign err  = bad;
    assign word = bad ? 32'h0 : packed_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            errCount <= '0;
        else if (out_fire && bus.outErr && !(&errCount))
            errCount <= errCount + 1'b1;
    end
`else
    assign err      = 1'b0;
    assign word     = packed_word;
    assign errCount = '0;
`endif

    assign addr_use = start ? baseAddr : addr_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            addr_cnt <= '0;
        else if (accept)
            addr_cnt <= addr_use + ADDR_W'(4);
        else if (start)
            addr_cnt <= baseAddr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.outValid <= 1'b0;
            bus.outInstr <= '0;
            bus.outAddr  <= '0;
            bus.outErr   <= 1'b0;
        end else if (accept) begin
            bus.outValid <= 1'b1;
            bus.outInstr <= word;
            bus.outAddr  <= addr_use;
            bus.outErr   <= err;
        end else if (out_fire) begin
            bus.outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wordCount <= '0;
        else if (start)
            wordCount <= '0;
        else if (out_fire)
            wordCount <= wordCount + 1'b1;
    end
endmodule
